// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding,
// timeout defaults and the baud constants of the UART it feeds.
package uart_tx_sched_pkg;

  // 2-bit scheduler state encoding
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2,
    ST_HOLD       = 2'd3
  } state_e;

  localparam int DEF_N_REQ         = 2;
  localparam int DEF_LOCK_TIMEOUT  = 4096;
  localparam int DEF_START_TIMEOUT = 16;

  // Baud setup of the downstream UART (100 MHz / 1.152 Mbaud -> 87 clk/bit)
  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_BAUD   = 1_152_000;

  // Clocks per bit, rounded to nearest
  function automatic int bit_period(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int DEF_BIT_PERIOD = bit_period(DEF_CLK_HZ, DEF_BAUD);

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin priority pick: the first asserted request
// found when scanning from ptr_i upward, wrapping at N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic found;
  int   idx;

  // Rotating scan; the first hit wins, later hits are masked by found
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[idx]) begin
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = IDX_W'(idx);
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART transmitter between N_REQ
// byte streams. The grant is held for a whole message so messages never
// interleave on the wire; a stalled owner loses the grant after
// LOCK_TIMEOUT idle cycles, and a UART that never starts a frame is
// abandoned after START_TIMEOUT cycles.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_busy_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               lock_timeout_o,
  output logic               start_err_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int LT_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W  = $clog2(START_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               last_q, last_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               lock_to_q, lock_to_d;
  logic               start_err_q, start_err_d;
  logic [LT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [ST_W-1:0]    start_cnt_q, start_cnt_d;

  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic [N_REQ-1:0]   ready;
  logic               accept;
  logic               byte_done;
  logic [IDX_W-1:0]   ptr_after_owner;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (win_oh),
    .gnt_idx_o (win_idx)
  );

  // Ready: arbiter winner in IDLE, the owner alone in HOLD; never while
  // the UART is busy or the block is in reset
  always_comb begin
    ready = '0;
    if (rst_n && !tx_busy_i) begin
      case (state_q)
        ST_IDLE: ready = win_oh;
        ST_HOLD: ready = grant_q;
        default: ready = '0;
      endcase
    end
  end

  assign accept  = |(ready & req_valid_i);
  assign sel_idx = (state_q == ST_HOLD) ? owner_q : win_idx;

  // Byte/last mux for the requester being served
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDX_W'(k) == sel_idx) begin
        sel_data = req_data_i[8*k +: 8];
        sel_last = req_last_i[k];
      end
    end
  end

  assign ptr_after_owner = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Next-state and datapath; pulses default low so they last one cycle
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    grant_d     = grant_q;
    lock_to_d   = 1'b0;
    start_err_d = 1'b0;
    byte_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          owner_d    = win_idx;
          last_d     = sel_last;
          grant_d    = win_oh;
          state_d    = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        if (tx_busy_i) begin
          tx_valid_d = 1'b0;
          state_d    = ST_WAIT_DONE;
        end else if (start_cnt_q == ST_W'(START_TIMEOUT - 1)) begin
          // UART never started: drop the byte and carry on as if sent
          tx_valid_d  = 1'b0;
          start_err_d = 1'b1;
          byte_done   = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) byte_done = 1'b1;
      end
      ST_HOLD: begin
        if (accept) begin
          tx_data_d  = sel_data;
          tx_valid_d = 1'b1;
          last_d     = sel_last;
          state_d    = ST_WAIT_START;
        end else if (lock_cnt_q == LT_W'(LOCK_TIMEOUT - 1)) begin
          lock_to_d = 1'b1;
          rr_ptr_d  = ptr_after_owner;
          grant_d   = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // End of a byte: release on message end, otherwise keep the owner
    if (byte_done) begin
      if (last_q) begin
        rr_ptr_d = ptr_after_owner;
        grant_d  = '0;
        state_d  = ST_IDLE;
      end else begin
        state_d  = ST_HOLD;
      end
    end
  end

  // Timers restart on every state change and only run in their own state
  always_comb begin
    lock_cnt_d  = '0;
    start_cnt_d = '0;
    if (state_d == state_q) begin
      if (state_q == ST_HOLD)       lock_cnt_d  = lock_cnt_q + 1'b1;
      if (state_q == ST_WAIT_START) start_cnt_d = start_cnt_q + 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      last_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      grant_q     <= '0;
      lock_to_q   <= 1'b0;
      start_err_q <= 1'b0;
      lock_cnt_q  <= '0;
      start_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      grant_q     <= grant_d;
      lock_to_q   <= lock_to_d;
      start_err_q <= start_err_d;
      lock_cnt_q  <= lock_cnt_d;
      start_cnt_q <= start_cnt_d;
    end
  end

  assign req_ready_o    = ready;
  assign tx_data_o      = tx_data_q;
  assign tx_valid_o     = tx_valid_q;
  assign grant_o        = grant_q;
  assign lock_timeout_o = lock_to_q;
  assign start_err_o    = start_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: per-requester message queues drive the byte
// streams, a UART stub answers tx_valid_o with a busy frame, and a
// monitor compares every issued byte against a queue filled by a
// message-level round-robin model.
module tb_uart_tx_sched;

  localparam int N  = 2;
  localparam int LT = 32;
  localparam int ST = 16;

  typedef struct packed {logic [7:0] d; logic l;} ent_t;
  typedef struct packed {logic [N-1:0] g; logic [7:0] d;} exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           lock_to;
  logic           start_err;

  int   n_chk = 0;
  int   n_pass = 0;
  ent_t drv_q[N][$];
  exp_t exp_q[$];
  int   gap[N];
  int   max_gap = 0;
  int   bit_cyc = 4;
  logic uart_dead = 1'b0;
  logic [N-1:0] hs;
  logic prev_hs = 1'b0;
  logic mon_prev = 1'b0;
  int   stub_cnt;

  uart_tx_sched #(.N_REQ(N), .LOCK_TIMEOUT(LT), .START_TIMEOUT(ST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_busy_i      (tx_busy),
    .grant_o        (grant),
    .lock_timeout_o (lock_to),
    .start_err_o    (start_err)
  );

  always #5 clk = ~clk;

  task automatic check(input logic ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // UART stub: a frame of 10 bit times starts when valid is seen idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      stub_cnt <= 0;
    end else if (tx_busy) begin
      if (stub_cnt <= 1) tx_busy <= 1'b0;
      stub_cnt <= stub_cnt - 1;
    end else if (tx_valid && !uart_dead) begin
      tx_busy  <= 1'b1;
      stub_cnt <= 10 * bit_cyc;
    end
  end

  // Requester drivers: present queue heads, pop on handshake, optional
  // short stalls between bytes of the same message
  initial begin
    req_valid = '0; req_data = '0; req_last = '0; hs = '0;
    for (int k = 0; k < N; k++) gap[k] = 0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_hs)
        check(tx_valid == 1'b1, "accept_to_valid_1cyc", 32'(tx_valid), 32'd1);
      for (int k = 0; k < N; k++) begin
        if (hs[k] && drv_q[k].size() > 0) begin
          ent_t e;
          e = drv_q[k].pop_front();
          if (!e.l && max_gap > 0) gap[k] = $urandom_range(0, max_gap);
        end
        if (gap[k] > 0) begin
          gap[k]--;
          req_valid[k] = 1'b0;
        end else if (drv_q[k].size() > 0) begin
          req_valid[k]        = 1'b1;
          req_data[8*k +: 8]  = drv_q[k][0].d;
          req_last[k]         = drv_q[k][0].l;
        end else begin
          req_valid[k] = 1'b0;
        end
      end
      #1;
      hs = rst_n ? (req_valid & req_ready) : '0;
      prev_hs = |hs;
      if (|hs)
        check($onehot(req_ready) && !tx_busy, "ready_onehot_not_busy",
              32'(req_ready), 32'(hs));
    end
  end

  // Monitor: each rising tx_valid_o is one issued byte
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && !mon_prev) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_issue", 32'(tx_data), 32'd0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check(tx_data == x.d, "wire_byte", 32'(tx_data), 32'(x.d));
          check(grant == x.g, "grant_owner", 32'(grant), 32'(x.g));
        end
      end
      mon_prev = tx_valid;
    end
  end

  // Reference: messages go out whole; next owner is the first requester
  // with pending data at or after the one following the previous owner
  task automatic predict();
    ent_t m[N][$];
    int   ptr;
    int   k;
    ent_t e;
    exp_t x;
    ptr = 0;
    for (int i = 0; i < N; i++) m[i] = drv_q[i];
    forever begin
      k = -1;
      for (int i = 0; i < N; i++)
        if (k < 0 && m[(ptr + i) % N].size() > 0) k = (ptr + i) % N;
      if (k < 0) break;
      do begin
        e = m[k].pop_front();
        x.g = '0;
        x.g[k] = 1'b1;
        x.d = e.d;
        exp_q.push_back(x);
      end while (!e.l && m[k].size() > 0);
      ptr = (k + 1) % N;
    end
  endtask

  function automatic logic drivers_empty();
    logic r;
    r = 1'b1;
    for (int k = 0; k < N; k++) if (drv_q[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(drivers_empty() && !tx_valid && !tx_busy && grant == '0)) begin
      @(negedge clk);
      n++;
    end
    check(n < budget, name, 32'(n), 32'(budget));
    check(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check(tx_valid == 1'b0, "rst_tx_valid", 32'(tx_valid), 32'd0);
    check(tx_data == 8'h00, "rst_tx_data", 32'(tx_data), 32'd0);
    check(grant == '0, "rst_grant", 32'(grant), 32'd0);
    check(req_ready == '0, "rst_ready", 32'(req_ready), 32'd0);
    check(!lock_to && !start_err, "rst_pulses", 32'({lock_to, start_err}), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin drv_q[k].delete(); gap[k] = 0; end
    exp_q.delete();
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_msg(input int k, input logic [7:0] d, input logic l);
    ent_t e;
    e.d = d;
    e.l = l;
    drv_q[k].push_back(e);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int nm;
    int len;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // "Hi\n" from req0 at 87 clk/bit
    do_reset();
    bit_cyc = 87;
    push_msg(0, 8'h48, 1'b0); push_msg(0, 8'h69, 1'b0); push_msg(0, 8'h0A, 1'b1);
    predict();
    wait_idle(5000, "hi_msg_done");

    // Two 2-byte messages contending from reset
    do_reset();
    bit_cyc = 4;
    push_msg(0, 8'hA0, 1'b0); push_msg(0, 8'hA1, 1'b1);
    push_msg(1, 8'hB0, 1'b0); push_msg(1, 8'hB1, 1'b1);
    predict();
    wait_idle(2000, "two_msgs_done");

    // Back-to-back single-byte messages alternate between requesters
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_msg(0, 8'h10 + 8'(i), 1'b1);
      push_msg(1, 8'h20 + 8'(i), 1'b1);
    end
    predict();
    wait_idle(3000, "alternate_done");

    // Owner stalls mid-message: grant revoked after LT idle cycles
    do_reset();
    push_msg(0, 8'h55, 1'b0);
    push_msg(1, 8'h66, 1'b1);
    predict();
    n = 0;
    while (!tx_busy && n < 200) begin @(negedge clk); n++; end
    while (tx_busy && n < 400) begin @(negedge clk); n++; end
    // busy seen low here; the FSM enters HOLD on the next edge, so the
    // pulse lands LT cycles after that, i.e. LT+1 negedges from now
    n = 0;
    while (!lock_to && n < 100) begin @(negedge clk); n++; end
    check(n == LT + 1, "lock_timeout_latency", 32'(n), 32'(LT + 1));
    #2;
    check(grant == '0, "lock_grant_released", 32'(grant), 32'd0);
    check(req_ready == 2'b10, "lock_next_ready", 32'(req_ready), 32'b10);
    @(negedge clk);
    check(lock_to == 1'b0, "lock_pulse_width", 32'(lock_to), 32'd0);
    wait_idle(1000, "lock_done");

    // Dead UART: each byte is abandoned after ST cycles of valid
    do_reset();
    uart_dead = 1'b1;
    push_msg(0, 8'h77, 1'b1);
    push_msg(1, 8'h88, 1'b1);
    predict();
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!tx_valid && n < 50) begin @(negedge clk); n++; end
      n = 0;
      while (tx_valid && n < 100) begin n++; @(negedge clk); end
      check(n == ST, "start_valid_width", 32'(n), 32'(ST));
      check(start_err == 1'b1, "start_err_pulse", 32'(start_err), 32'd1);
      check(grant == '0, "start_err_release", 32'(grant), 32'd0);
      @(negedge clk);
      check(start_err == 1'b0, "start_err_width", 32'(start_err), 32'd0);
    end
    wait_idle(500, "start_err_done");
    uart_dead = 1'b0;

    // Reset in WAIT_DONE of a multi-byte message from req1 (rr_ptr=1)
    do_reset();
    push_msg(0, 8'h01, 1'b1);
    predict();
    wait_idle(500, "pre_reset_msg");
    push_msg(1, 8'hC0, 1'b0); push_msg(1, 8'hC1, 1'b0); push_msg(1, 8'hC2, 1'b1);
    predict();
    n = 0;
    while (!(tx_busy && !tx_valid) && n < 500) begin @(negedge clk); n++; end
    check(n < 500, "reach_wait_done", 32'(n), 32'd500);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int k = 0; k < N; k++) begin drv_q[k].delete(); gap[k] = 0; end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_msg(0, 8'hD0, 1'b1);
    push_msg(1, 8'hD1, 1'b1);
    predict();
    wait_idle(1000, "post_reset_done");

    // Randomized message mixes with short mid-message stalls
    for (int r = 0; r < 4; r++) begin
      do_reset();
      bit_cyc = $urandom_range(1, 3);
      max_gap = 3;
      for (int k = 0; k < N; k++) begin
        nm = $urandom_range(1, 5);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            push_msg(k, 8'($urandom), (b == len - 1));
        end
      end
      predict();
      wait_idle(20000, "random_done");
      max_gap = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one 8N1 UART transmitter between N_REQ byte sources (e.g. CPU MMIO port, boot/debug message ROM).
- Each source streams bytes over a valid/ready interface and marks the final byte of a message with last.
- The grant is held per message, so messages never interleave on the wire.
- Sits between the requesters and the UART TX instance. The UART's test mode is tied off; its valid input is driven by tx_valid_o and its busy output feeds tx_busy_i.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- LOCK_TIMEOUT, 4096, idle cycles a message owner may stall mid-message before its grant is revoked.
- START_TIMEOUT, 16, cycles to wait for tx_busy_i to rise after issuing a byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  per-requester byte valid
- req_data_i  in  8*N_REQ  byte for requester k at [8k+7:8k]
- req_last_i  in  N_REQ  byte is the last of its message
- req_ready_o  out  N_REQ  byte accepted this cycle when valid&ready
- tx_data_o  out  8  byte to UART
- tx_valid_o  out  1  issue request to UART
- tx_busy_i  in  1  UART busy/active
- grant_o  out  N_REQ  one-hot current owner, 0 when no owner
- lock_timeout_o  out  1  1-cycle pulse: grant revoked by LOCK_TIMEOUT
- start_err_o  out  1  1-cycle pulse: UART failed to start within START_TIMEOUT

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, tx_valid_o=0, tx_data_o=0, grant_o=0, pulses=0, timers=0.
  - req_ready_o=0 while rst_n=0.
- States: IDLE, WAIT_START, WAIT_DONE, HOLD.
- IDLE:
  - winner = first k with req_valid_i[k], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready_o[winner]=1 combinationally iff tx_busy_i=0; all other ready bits are 0.
  - On accept: tx_data_o<=byte, tx_valid_o<=1, owner<=winner, last_q<=req_last_i[winner], grant_o<=onehot(winner), go to WAIT_START. Latency from accept edge to tx_valid_o high is 1 cycle.
- WAIT_START:
  - tx_valid_o stays 1 until tx_busy_i=1 is sampled; then tx_valid_o<=0 and go to WAIT_DONE.
  - If START_TIMEOUT cycles elapse without busy: tx_valid_o<=0, start_err_o pulses, byte is dropped, and the state proceeds as if the byte had completed.
- WAIT_DONE:
  - Wait for tx_busy_i=0.
  - If last_q=1: go to IDLE, rr_ptr<=(owner+1) mod N_REQ, grant_o<=0.
  - Otherwise go to HOLD.
- HOLD:
  - Only the owner sees req_ready_o=1, gated by !tx_busy_i.
  - Accept behaves as in IDLE and goes to WAIT_START.
  - The lock timer counts cycles without an accept. On reaching LOCK_TIMEOUT: lock_timeout_o pulses, go to IDLE, rr_ptr<=owner+1, grant_o<=0.
  - Other requesters' valids are ignored while in HOLD.
- At most one byte is in flight. req_ready_o is never 1 in WAIT_START or WAIT_DONE.
- A single-byte message (last=1 on the first byte) releases the grant after that byte.
- A requester deasserting valid without handshake is legal and is simply not served.
- req_data_i/req_last_i are sampled only on accept.
- rr_ptr wraps from N_REQ-1 to 0.
- Reset mid-frame: the block returns to IDLE immediately and tx_valid_o drops. The UART shares rst_n, so no partial-frame recovery is required.
- Timer widths: $clog2(LOCK_TIMEOUT+1) and $clog2(START_TIMEOUT+1). Timers clear on every state entry.

Decomposition:
- Shared header uart_defs.vh: state encodings (2-bit), default BIT_PERIOD/baud constants, timeout defaults.
- One sub-module: rr_arbiter (N_REQ requests, rr_ptr in, one-hot winner out, purely combinational priority rotate). The FSM, timers and datapath mux stay in uart_tx_sched.

Test Plan:
- Reset, then req0 sends "Hi\n" (last on '\n') with UART at 100 MHz/1152000 (87 clk/bit) -> three frames 0x48, 0x69, 0x0A in order. tx_valid_o rises 1 cycle after each accept; grant_o=01 throughout, 00 after the final busy fall.
- req0 and req1 both valid in IDLE from reset, each with a 2-byte message -> req0 served first (rr_ptr=0), then req1. Wire order is 0xA0,0xA1,0xB0,0xB1 with no interleave; rr_ptr=0 afterwards.
- req1 sends 1-byte messages continuously while req0 also requests -> grants alternate 0,1,0,1, so neither requester is starved.
- Owner req0 sends 1 byte without last, then idles; set LOCK_TIMEOUT=32 -> lock_timeout_o pulses 32 cycles after HOLD entry. req1's pending byte is then accepted in the next IDLE cycle.
- tx_busy_i held 0 (UART stub dead), START_TIMEOUT=16 -> tx_valid_o high for 16 cycles, then start_err_o pulses and the FSM releases per last.
- Assert rst_n low during WAIT_DONE of a multi-byte message -> outputs return to reset values asynchronously. After release, IDLE with rr_ptr=0 and no stale grant.
